mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between the IF stage
//  (instruction fetch, read-only) and the MEM stage (load/store).
//  Grants one requester at a time and drives a req/ack memory interface
//  with variable wait states.
//  Returns a one-cycle ready pulse with read data to the granted stage;
//  stage freeze logic consumes those ready pulses.
//  MEM has priority. A starvation counter guarantees IF forward progress.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width, all ports
//  STARVE_MAX  4   consecutive MEM grants with IF waiting before IF is forced
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-low (0 = reset)
//  if_req     in   1       IF read request; held until if_ready
//  if_addr    in   ADDR_W  IF read address
//  if_ready   out  1       1-cycle pulse: IF transaction complete
//  if_rdata   out  DATA_W  fetched word, valid with if_ready, held after
//  mem_req    in   1       MEM request; held until mem_ready
//  mem_we     in   1       1 = write, 0 = read
//  mem_addr   in   ADDR_W  MEM address
//  mem_wdata  in   DATA_W  store data
//  mem_ready  out  1       1-cycle pulse: MEM transaction complete
//  mem_rdata  out  DATA_W  load data, valid with mem_ready, held after
//  ram_req    out  1       memory request, held until ram_ack
//  ram_we     out  1       memory write enable
//  ram_addr   out  ADDR_W  memory address (registered)
//  ram_wdata  out  DATA_W  memory write data (registered)
//  ram_rdata  in   DATA_W  memory read data, valid with ram_ack
//  ram_ack    in   1       memory completion, 1-cycle, >=0 wait states
//  busy       out  1       1 while state != IDLE
// BEHAVIOUR
//  - Reset (rst=0): state IDLE; starve_cnt=0; every output 0, including
//    rdata registers. Reset mid-transaction abandons it: ram_req drops
//    asynchronously and no ready pulse is issued.
//  - States: IDLE, BUSY_IF, BUSY_MEM.
//  - IDLE arbitration, one decision per cycle:
//    - Only mem_req -> BUSY_MEM.
//    - Only if_req -> BUSY_IF.
//    - Both requests -> BUSY_IF if starve_cnt==STARVE_MAX, else BUSY_MEM.
//    - On a grant, the arbiter registers addr, we (0 for IF) and wdata into
//      ram_*. ram_req=1 from the next cycle.
//  - BUSY_x: ram_* held stable. On ram_ack -> IDLE; the next cycle asserts
//    x_ready=1 for exactly one cycle. Reads register ram_rdata into
//    x_rdata. Writes leave mem_rdata unchanged.
//  - Latency: request sampled in cycle 0 -> ram_req in cycle 1. With ack
//    in cycle 1+W, ready occurs in cycle 2+W (minimum 2 cycles).
//  - Ready-cycle masking: in the cycle x_ready=1, x_req is ignored, so a
//    stale request cannot be regranted. Back-to-back transactions
//    therefore have a 1-cycle gap.
//  - starve_cnt (0..STARVE_MAX, saturating) updates on each grant:
//    - MEM grant while if_req=1: +1.
//    - MEM grant while if_req=0: cleared.
//    - IF grant: cleared.
//  - ram_ack in IDLE is ignored. A requester dropping req mid-transaction
//    does not abort it; the ready pulse is still issued.
//  - if_ready and mem_ready are never high in the same cycle.
//  - busy = (state != IDLE).
// TESTING
//  1. IF read: if_req=1, if_addr=0x10; ram_ack in the ram_req cycle with
//     ram_rdata=0xE3A00001 -> ram_addr=0x10, ram_we=0. if_ready=1 two
//     cycles after the request, with if_rdata=0xE3A00001.
//  2. Simultaneous: if_req (0x20) and mem_req read (0x100) together, 0 wait
//     states -> ram_addr=0x100 first with a mem_ready pulse, then 0x20 with
//     an if_ready pulse.
//  3. Starvation: STARVE_MAX=2, mem_req held high continuously, if_req
//     high -> exactly 2 MEM grants, then an IF grant, then MEM resumes;
//     starve_cnt reads 0 after the IF grant.
//  4. Write: mem_we=1, addr 0x104, wdata 0xDEADBEEF, 3 wait states ->
//     ram_we=1 and ram_wdata=0xDEADBEEF held for 4 cycles. mem_ready comes
//     one cycle after ram_ack; mem_rdata unchanged.
//  5. Reset mid-op: rst=0 during BUSY_MEM -> ram_req=0 immediately and no
//     mem_ready. After rst=1 with if_req held, the IF request is served
//     normally.
//  6. Masking: if_req held one cycle past if_ready -> no second IF grant
//     in the ready cycle; a grant occurs the next cycle only if if_req is
//     still 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the IF stage
// (read-only fetch) and the MEM stage (load/store). MEM has priority; a
// saturating starvation counter forces an IF grant after STARVE_MAX
// consecutive MEM grants taken while IF was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant_if;
  logic             grant_mem;

  // Grant decision for the current IDLE cycle. No grant is made while a
  // ready pulse is out: the requester that just completed may still hold a
  // stale request, and holding off the other requester too keeps the
  // one-cycle gap uniform so the starvation counter sees every contention.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    starved   = (starve_cnt == CNT_W'(STARVE_MAX));
    if (state == IDLE && !if_ready && !mem_ready) begin
      if (mem_req && !(if_req && starved)) begin
        grant_mem = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  // Arbiter FSM: registers the granted request onto ram_*, waits for
  // ram_ack, then issues a one-cycle ready pulse with captured read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      busy       <= 1'b0;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_ready   <= 1'b0;
      if_rdata   <= '0;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            state     <= BUSY_MEM;
            busy      <= 1'b1;
            ram_req   <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            if (!if_req) begin
              starve_cnt <= '0;
            end else if (!starved) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (grant_if) begin
            state      <= BUSY_IF;
            busy       <= 1'b1;
            ram_req    <= 1'b1;
            ram_we     <= 1'b0;
            ram_addr   <= if_addr;
            ram_wdata  <= '0;
            starve_cnt <= '0;
          end
        end
        BUSY_IF: begin
          if (ram_ack) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ram_req  <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= ram_rdata;
          end
        end
        BUSY_MEM: begin
          if (ram_ack) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ram_req   <= 1'b0;
            mem_ready <= 1'b1;
            if (!ram_we) begin
              mem_rdata <= ram_rdata;
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          ram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
